// File: rtl/root_hub_stage_sequencer.sv
// Root-hub stage sequencer for the multi-FPGA union-find decoder: runs LOAD/GROW/MERGE,
// aggregates masked child flags, and reports iteration, cycle count, deadlock and cardinality.
module root_hub_stage_sequencer #(
    parameter int unsigned DOWNSTREAM_FIFO_COUNT   = 4,
    parameter int unsigned STATE_SIGNAL_WIDTH      = 2,
    parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
    parameter int unsigned LOAD_CYCLES             = 3,
    parameter int unsigned SYNC_LATENCY            = 2,
    parameter int unsigned QUIET_CYCLES            = 2,
    parameter int unsigned MERGE_TIMEOUT           = 64,
    parameter int unsigned MAX_ITERATIONS          = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               new_round_start,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]   channel_enable,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]   downstream_has_message_flying,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]   downstream_has_odd_clusters,
    output logic [STATE_SIGNAL_WIDTH-1:0]      downstream_state_signal,
    output logic                               upstream_has_message_flying,
    output logic                               busy,
    output logic                               result_valid,
    output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    output logic [31:0]                        cycle_counter,
    output logic                               deadlock,
    output logic                               final_cardinality
);

    localparam int unsigned DwellMax = (MERGE_TIMEOUT > SYNC_LATENCY) ? MERGE_TIMEOUT
                                                                      : SYNC_LATENCY;
    localparam int unsigned DW = $clog2(DwellMax + 1);
    localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
    localparam int unsigned LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int unsigned IW = ITERATION_COUNTER_WIDTH;

    localparam logic [DW-1:0] SyncVal    = DW'(SYNC_LATENCY);
    localparam logic [DW-1:0] TimeoutVal = DW'(MERGE_TIMEOUT);
    localparam logic [QW-1:0] QuietVal   = QW'(QUIET_CYCLES);
    localparam logic [LW-1:0] LastLoad   = LW'(LOAD_CYCLES - 1);
    localparam logic [IW-1:0] MaxIter    = IW'(MAX_ITERATIONS);

    typedef enum logic [2:0] {StIdle, StLoad, StGrow, StMerge, StResult} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] load_q, load_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          dead_q, dead_d;
    logic          card_q, card_d;
    logic          flying_q, odd_q;

    logic          settled;
    logic [QW-1:0] quiet_next;
    logic          merge_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            load_q   <= '0;
            dwell_q  <= '0;
            quiet_q  <= '0;
            iter_q   <= '0;
            cycle_q  <= '0;
            dead_q   <= 1'b0;
            card_q   <= 1'b0;
            flying_q <= 1'b0;
            odd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            dwell_q  <= dwell_d;
            quiet_q  <= quiet_d;
            iter_q   <= iter_d;
            cycle_q  <= cycle_d;
            dead_q   <= dead_d;
            card_q   <= card_d;
            flying_q <= |(downstream_has_message_flying & channel_enable);
            odd_q    <= |(downstream_has_odd_clusters & channel_enable);
        end
    end

    // Flags are ignored while the link round trip settles after entering MERGE.
    always_comb begin
        settled    = (dwell_q >= SyncVal);
        quiet_next = quiet_q + QW'(1);
        merge_done = settled && !flying_q && (quiet_next == QuietVal);
    end

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        dwell_d = dwell_q;
        quiet_d = quiet_q;
        iter_d  = iter_q;
        cycle_d = cycle_q;
        dead_d  = dead_q;
        card_d  = card_q;

        if ((state_q == StLoad || state_q == StGrow || state_q == StMerge) &&
            (cycle_q != 32'hFFFF_FFFF)) begin
            cycle_d = cycle_q + 32'd1;
        end

        case (state_q)
            StIdle: begin
                if (new_round_start) begin
                    state_d = StLoad;
                    load_d  = '0;
                    iter_d  = '0;
                    cycle_d = '0;
                    dead_d  = 1'b0;
                    card_d  = 1'b0;
                end
            end
            StLoad: begin
                if (load_q == LastLoad) begin
                    state_d = StGrow;
                end else begin
                    load_d = load_q + LW'(1);
                end
            end
            StGrow: begin
                iter_d  = iter_q + IW'(1);
                dwell_d = '0;
                quiet_d = '0;
                state_d = StMerge;
            end
            StMerge: begin
                dwell_d = dwell_q + DW'(1);
                if (settled) begin
                    quiet_d = flying_q ? '0 : quiet_next;
                end
                // Completion takes priority over a timeout landing on the same cycle.
                if (merge_done) begin
                    if (odd_q && (iter_q < MaxIter)) begin
                        state_d = StGrow;
                    end else begin
                        state_d = StResult;
                        dead_d  = 1'b0;
                        card_d  = odd_q;
                    end
                end else if (dwell_d == TimeoutVal) begin
                    state_d = StResult;
                    dead_d  = 1'b1;
                    card_d  = odd_q;
                end
            end
            StResult: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            StLoad:  downstream_state_signal = STATE_SIGNAL_WIDTH'(1);
            StGrow:  downstream_state_signal = STATE_SIGNAL_WIDTH'(2);
            StMerge: downstream_state_signal = STATE_SIGNAL_WIDTH'(3);
            default: downstream_state_signal = '0;
        endcase
        busy                        = (state_q != StIdle);
        result_valid                = (state_q == StResult);
        upstream_has_message_flying = flying_q;
        iteration_counter           = iter_q;
        cycle_counter               = cycle_q;
        deadlock                    = dead_q;
        final_cardinality           = card_q;
    end

endmodule

// File: doc/root_hub_stage_sequencer.md
Name: root_hub_stage_sequencer

Overview:
- Parametrised root-hub stage sequencer for the multi-FPGA union-find decoder, with a variable child-channel count.
- Sits at the top of the hub tree. It aggregates per-child has_message_flying / has_odd_clusters flags and broadcasts the decoder stage on downstream_state_signal.
- Runs the LOAD/GROW/MERGE loop and reports iteration count, cycle count, deadlock and final cardinality.
- New over the previous root hub: per-channel enable mask, configurable link-settle latency, quiet-window merge detection, merge timeout, and an iteration cap.

Parameters:
- DOWNSTREAM_FIFO_COUNT, 4, number of child channels (≥1).
- STATE_SIGNAL_WIDTH, 2, width of broadcast stage code (≥2).
- ITERATION_COUNTER_WIDTH, 8, iteration counter width.
- LOAD_CYCLES, 3, cycles spent broadcasting LOAD (≥1).
- SYNC_LATENCY, 2, MERGE cycles during which child flags are ignored (round-trip link latency, ≥0).
- QUIET_CYCLES, 2, consecutive cycles of no enabled flying flag required to end MERGE (≥1).
- MERGE_TIMEOUT, 64, maximum MERGE dwell in cycles before deadlock is declared.
- MAX_ITERATIONS, 8, maximum GROW count per round (≤2^ITERATION_COUNTER_WIDTH−1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- new_round_start  in  1  single-cycle start pulse; sampled only in IDLE.
- channel_enable  in  DOWNSTREAM_FIFO_COUNT  1 = channel participates; masked channels are ignored.
- downstream_has_message_flying  in  DOWNSTREAM_FIFO_COUNT  per-child flying flag.
- downstream_has_odd_clusters  in  DOWNSTREAM_FIFO_COUNT  per-child odd-cluster flag.
- downstream_state_signal  out  STATE_SIGNAL_WIDTH  broadcast stage: 0 IDLE/RESULT, 1 LOAD, 2 GROW, 3 MERGE; zero-extended.
- upstream_has_message_flying  out  1  registered OR of enabled flying flags (debug).
- busy  out  1  high in any state except IDLE.
- result_valid  out  1  one-cycle pulse in RESULT.
- iteration_counter  out  ITERATION_COUNTER_WIDTH  GROW count of the current/last round.
- cycle_counter  out  32  cycles spent in LOAD+GROW+MERGE this round; saturates at 32'hFFFFFFFF.
- deadlock  out  1  held from RESULT until the next round starts; 1 = round ended by timeout.
- final_cardinality  out  1  held from RESULT until the next round starts; 1 = odd clusters remained.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs and counters 0; input registers cleared. Reset mid-operation aborts the round immediately. No result_valid is produced for the aborted round.
- Input stage: flying_r = |(downstream_has_message_flying & channel_enable) and odd_r = |(downstream_has_odd_clusters & channel_enable), registered once. All MERGE decisions use the registered values. upstream_has_message_flying = flying_r.
- IDLE: if new_round_start=1, go to LOAD and clear iteration_counter, cycle_counter, deadlock and final_cardinality. new_round_start in any other state is ignored.
- LOAD: stay exactly LOAD_CYCLES cycles, then go to GROW.
- GROW: 1 cycle; iteration_counter += 1; then go to MERGE.
- MERGE, on entry: clear settle, quiet and merge-dwell counters.
  - For the first SYNC_LATENCY cycles, flags are ignored.
  - Afterwards, quiet increments when flying_r=0 and resets to 0 when flying_r=1.
  - Done when quiet reaches QUIET_CYCLES, so minimum dwell is SYNC_LATENCY+QUIET_CYCLES cycles.
- On MERGE done:
  - odd_r=1 and iteration_counter<MAX_ITERATIONS → GROW.
  - Otherwise → RESULT with final_cardinality=odd_r and deadlock=0.
- Timeout: if merge dwell reaches MERGE_TIMEOUT without done, go to RESULT with deadlock=1 and final_cardinality=odd_r. If done and timeout occur in the same cycle, done wins.
- RESULT: 1 cycle; result_valid=1; state_signal=0; then go to IDLE.
- cycle_counter increments every cycle in LOAD/GROW/MERGE and is frozen in RESULT and IDLE.
- iteration_counter holds its value until the next round start.
- Stage-signal output is registered: downstream_state_signal reflects the current state register, with no extra latency.
- Masked channels: changes on a channel with channel_enable=0 never affect any output. Changing channel_enable mid-round takes effect at the input register, 1 cycle later.

Test Plan:
1. Defaults, all flags 0, pulse new_round_start → LOAD 3 cycles, GROW 1, MERGE 4, then result_valid. At result_valid: iteration=1, cycle_counter=8, final_cardinality=0, deadlock=0.
2. odd on ch2 held 1 through the first two MERGE decisions, then 0 → iteration=3, final_cardinality=0, cycle_counter=3+3×(1+4)=18.
3. flying on ch1 pulsed high for 1 cycle after settle in the first MERGE → quiet resets and MERGE extends by the pulse offset. Result: iteration=1, deadlock=0.
4. flying ch1 stuck 1 → RESULT after 64 MERGE cycles with deadlock=1. Repeat with channel_enable=4'b1101 → scenario-1 results.
5. odd ch0 stuck 1 → iteration=8, final_cardinality=1, deadlock=0, cycle_counter=3+8×5=43.
6. reset=0 during MERGE → all outputs 0 immediately and no result_valid. new_round_start pulsed during GROW is ignored.
